// File: rtl/rvdff_skid_slice.sv
// Registered valid/ready pipeline slice: a main register feeds the consumer and a
// one-entry skid register absorbs the word accepted while in_ready is still high.
//
//   state | meaning
//   EMPTY | nothing held; out_valid=0, in_ready=1
//   ONE   | main holds the head entry; out_valid=1, in_ready=1
//   FULL  | main and skid both hold entries; out_valid=1, in_ready=0
module rvdff_skid_slice #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding equals the number of held entries, so the state drives occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             up_xfer;
  logic             dn_xfer;

  assign up_xfer = in_valid & in_ready_q;
  assign dn_xfer = out_valid_q & out_ready;

  always_comb begin
    state_nxt = state_q;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state_q)
      EMPTY: begin
        if (up_xfer) begin
          state_nxt = ONE;
          main_nxt  = in_data;
        end
      end
      ONE: begin
        if (up_xfer && dn_xfer) begin
          main_nxt = in_data;
        end else if (up_xfer) begin
          state_nxt = FULL;
          skid_nxt  = in_data;
        end else if (dn_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (dn_xfer) begin
          state_nxt = ONE;
          main_nxt  = skid_q;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Handshake outputs are flopped from the next state, keeping both paths registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      main_q      <= main_nxt;
      skid_q      <= skid_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

endmodule
